// File: rtl/bg_mode_sequencer.sv
// ============================================================================
// Module  : bg_mode_sequencer
// Brief   : Fades the background between drawing modes, flashes it on demand
//           and scrolls the colour matrix; all outputs registered.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bg_mode_sequencer #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int FLASH_FRAMES    = 8,
    parameter int SCROLL_STEP     = 1,
    parameter int MAX_LEFT_X      = 500,
    parameter int INIT_LEFT_X     = 100
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        modeReqValid,
    input  logic [1:0]  modeReq,
    output logic        modeReqReady,
    input  logic        flashReq,
    output logic [1:0]  bgMode,
    output logic [3:0]  bgEnableMask,
    output logic [1:0]  brightness,
    output logic        flashActive,
    output logic [10:0] matrixLeftX,
    output logic [15:0] frameCount
);

    localparam int STEP_W  = $clog2(FRAMES_PER_STEP + 1);
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

    localparam logic [STEP_W-1:0]  c_step_final  = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [FLASH_W-1:0] c_flash_load  = FLASH_W'(FLASH_FRAMES);
    localparam logic [FLASH_W-1:0] c_flash_one   = FLASH_W'(1);
    localparam logic [11:0]        c_scroll_step = 12'(SCROLL_STEP);
    localparam logic [11:0]        c_max_left_x  = 12'(MAX_LEFT_X);
    localparam logic [10:0]        c_init_left_x = 11'(INIT_LEFT_X);

    localparam logic [1:0] c_mode_blank   = 2'd0;
    localparam logic [1:0] c_mode_borders = 2'd1;
    localparam logic [1:0] c_mode_rects   = 2'd2;
    localparam logic [1:0] c_mode_matrix  = 2'd3;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    state_t               state_q,        state_d;
    logic [1:0]           bgMode_q,       bgMode_d;
    logic [3:0]           bgEnableMask_q, bgEnableMask_d;
    logic [1:0]           brightness_q,   brightness_d;
    logic                 modeReqReady_q, modeReqReady_d;
    logic                 flashActive_q,  flashActive_d;
    logic [10:0]          matrixLeftX_q,  matrixLeftX_d;
    logic [15:0]          frameCount_q,   frameCount_d;
    logic [STEP_W-1:0]    step_cnt_q,     step_cnt_d;
    logic [FLASH_W-1:0]   flash_cnt_q,    flash_cnt_d;
    logic [1:0]           pendingMode_q,  pendingMode_d;

    logic                 w_accept;
    logic                 w_step_done;
    logic [11:0]          w_scroll_sum;

    function automatic logic [3:0] mask_for(input logic [1:0] mode);
        logic [3:0] mask;
        mask = 4'b0000;
        case (mode)
            c_mode_blank:   mask = 4'b0000;
            c_mode_borders: mask = 4'b0011;
            c_mode_rects:   mask = 4'b0101;
            c_mode_matrix:  mask = 4'b1001;
            default:        mask = 4'b0000;
        endcase
        return mask;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= SHOW;
            bgMode_q       <= c_mode_blank;
            bgEnableMask_q <= 4'b0000;
            brightness_q   <= 2'd3;
            modeReqReady_q <= 1'b1;
            flashActive_q  <= 1'b0;
            matrixLeftX_q  <= c_init_left_x;
            frameCount_q   <= 16'd0;
            step_cnt_q     <= '0;
            flash_cnt_q    <= '0;
            pendingMode_q  <= 2'd0;
        end else begin
            state_q        <= state_d;
            bgMode_q       <= bgMode_d;
            bgEnableMask_q <= bgEnableMask_d;
            brightness_q   <= brightness_d;
            modeReqReady_q <= modeReqReady_d;
            flashActive_q  <= flashActive_d;
            matrixLeftX_q  <= matrixLeftX_d;
            frameCount_q   <= frameCount_d;
            step_cnt_q     <= step_cnt_d;
            flash_cnt_q    <= flash_cnt_d;
            pendingMode_q  <= pendingMode_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bgMode_d       = bgMode_q;
        brightness_d   = brightness_q;
        flashActive_d  = flashActive_q;
        matrixLeftX_d  = matrixLeftX_q;
        step_cnt_d     = step_cnt_q;
        flash_cnt_d    = flash_cnt_q;
        pendingMode_d  = pendingMode_q;

        w_accept     = modeReqValid && modeReqReady_q;
        w_step_done  = (step_cnt_q == c_step_final);
        w_scroll_sum = {1'b0, matrixLeftX_q} + c_scroll_step;

        frameCount_d = startOfFrame ? frameCount_q + 16'd1 : frameCount_q;

        // Scrolling is judged on the pre-edge state, so the acceptance cycle still scrolls.
        if (state_q == SHOW && bgMode_q == c_mode_matrix && startOfFrame) begin
            matrixLeftX_d = (w_scroll_sum > c_max_left_x) ? 11'd0 : w_scroll_sum[10:0];
        end

        case (state_q)
            SHOW: begin
                if (w_accept && modeReq != bgMode_q) begin
                    pendingMode_d = modeReq;
                    state_d       = FADE_OUT;
                    step_cnt_d    = '0;
                    flash_cnt_d   = '0;
                    flashActive_d = 1'b0;
                end else if (flashReq && !w_accept) begin
                    flash_cnt_d   = c_flash_load;
                    flashActive_d = 1'b1;
                end else if (startOfFrame && flash_cnt_q != '0) begin
                    flash_cnt_d   = flash_cnt_q - c_flash_one;
                    flashActive_d = (flash_cnt_q != c_flash_one);
                end
            end
            FADE_OUT: begin
                if (startOfFrame) begin
                    if (w_step_done) begin
                        step_cnt_d   = '0;
                        brightness_d = brightness_q - 2'd1;
                        if (brightness_q == 2'd1) begin
                            bgMode_d = pendingMode_q;
                            state_d  = FADE_IN;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            FADE_IN: begin
                if (startOfFrame) begin
                    if (w_step_done) begin
                        step_cnt_d   = '0;
                        brightness_d = brightness_q + 2'd1;
                        if (brightness_q == 2'd2) begin
                            state_d = SHOW;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = SHOW;
                step_cnt_d = '0;
            end
        endcase

        // Ready and mask are registered copies of next-state facts so they move on the same edge.
        modeReqReady_d = (state_d == SHOW);
        bgEnableMask_d = mask_for(bgMode_d);
    end

    assign modeReqReady = modeReqReady_q;
    assign bgMode       = bgMode_q;
    assign bgEnableMask = bgEnableMask_q;
    assign brightness   = brightness_q;
    assign flashActive  = flashActive_q;
    assign matrixLeftX  = matrixLeftX_q;
    assign frameCount   = frameCount_q;

endmodule

`default_nettype wire

// File: doc/bg_mode_sequencer.md
BG_MODE_SEQUENCER -- requirements
Module: bg_mode_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- FRAMES_PER_STEP, 2: frames each brightness level is held during a fade.
- FLASH_FRAMES, 8: flash duration in frames.
- SCROLL_STEP, 1: colour-matrix left-X increment per frame.
- MAX_LEFT_X, 500: largest legal matrixLeftX; wrap point.
- INIT_LEFT_X, 100: matrixLeftX reset value.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: pixel clock.
- resetN, in, 1: asynchronous reset, active-low.
- startOfFrame, in, 1: one-cycle pulse at pixel (0,0).
- modeReqValid, in, 1: game controller requests a background mode.
- modeReq, in, 2: requested mode. 0 BLANK, 1 BORDERS, 2 RECTS, 3 MATRIX.
- modeReqReady, out, 1: request can be accepted this cycle.
- flashReq, in, 1: one-cycle pulse that requests a screen flash.
- bgMode, out, 2: mode currently applied to the background drawer.
- bgEnableMask, out, 4: layer enables. [0] border, [1] brackets, [2] rectangles, [3] colour matrix.
- brightness, out, 2: 3 is full, 0 is black. The drawer scales RGB by this value.
- flashActive, out, 1: the drawer inverts background colours while this is high.
- matrixLeftX, out, 11: colour-matrix left edge.
- frameCount, out, 16: count of startOfFrame pulses, wrapping.

Function
REQ-003 All outputs SHALL be registered. State values: SHOW, FADE_OUT, FADE_IN.
REQ-004 bgEnableMask SHALL follow bgMode: BLANK 0000, BORDERS 0011, RECTS 0101, MATRIX 1001.
REQ-005 modeReqReady SHALL be 1 only in SHOW.
- A request is accepted on a cycle where modeReqValid and modeReqReady are both 1.
REQ-006 Accepting a request with modeReq equal to bgMode SHALL leave the state at SHOW with no output change.
REQ-007 Accepting a request with a different modeReq SHALL:
- latch modeReq as pendingMode;
- enter FADE_OUT on the next cycle;
- clear flashActive and the flash counter.
REQ-008 In FADE_OUT, brightness SHALL decrement by 1 on every FRAMES_PER_STEP-th startOfFrame pulse.
- The first counted pulse is the first one after the acceptance cycle.
- On the cycle brightness becomes 0, bgMode is set to pendingMode and the state becomes FADE_IN.
REQ-009 In FADE_IN, brightness SHALL increment by 1 on every FRAMES_PER_STEP-th startOfFrame pulse.
- On the cycle brightness becomes 3, the state becomes SHOW.
- modeReqReady rises on the same clock edge as that transition.
REQ-010 The step counter SHALL be cleared on every state change, so each step lasts exactly FRAMES_PER_STEP frames.
REQ-011 A flashReq in SHOW SHALL set flashActive=1 and load the flash counter with FLASH_FRAMES.
- The counter decrements on each startOfFrame.
- flashActive clears on the cycle the counter reaches 0.
- A flashReq while already flashing reloads the counter.
- flashReq in FADE_OUT or FADE_IN is ignored.
REQ-012 If modeReqValid accepts and flashReq arrive on the same cycle, the mode request SHALL win and the flash SHALL be dropped.
REQ-013 In SHOW with bgMode MATRIX, each startOfFrame SHALL update matrixLeftX:
- if matrixLeftX + SCROLL_STEP > MAX_LEFT_X, matrixLeftX becomes 0;
- otherwise matrixLeftX becomes matrixLeftX + SCROLL_STEP.
- The sum is computed at 12 bits.
- In any other mode or state, matrixLeftX holds its value.
REQ-014 frameCount SHALL increment on every startOfFrame in all states and wrap from 0xFFFF to 0.
REQ-015 startOfFrame coinciding with request acceptance SHALL increment frameCount but SHALL NOT count as a fade step.
REQ-016 modeReq SHALL be sampled only on the acceptance cycle. Changes while not ready have no effect.

Reset
REQ-017 Asserting resetN low SHALL immediately force:
- state SHOW, bgMode 0, bgEnableMask 0000, brightness 3;
- modeReqReady 1, flashActive 0, matrixLeftX INIT_LEFT_X, frameCount 0;
- step counter, flash counter and pendingMode all 0.
REQ-018 Reset asserted mid-fade or mid-flash SHALL abandon the operation. No pending mode is applied after release.

Verification
REQ-019 The bench SHALL cover these directed scenarios (default parameters):
- Request mode 2 from reset. Expect:
  - modeReqReady low the next cycle;
  - brightness 3→2→1→0 at SOF 2, 4 and 6;
  - bgMode 2 and mask 0101 at SOF 6;
  - brightness back to 3 at SOF 12, with ready high at the same edge.
- Request mode 0 while in mode 0 → no state change, ready stays 1, brightness stays 3.
- Mode 3 in SHOW with matrixLeftX 499 → 500 at the next SOF, then 0.
  - Repeat with SCROLL_STEP 4 from 498 → 0.
- flashReq in SHOW → flashActive high for exactly 8 SOFs. A second flashReq at SOF 5 → high until SOF 13.
- Same-cycle flashReq and accepted mode change → flashActive stays 0 and the fade starts.
  - flashReq during FADE_IN is ignored.
- resetN low at SOF 3 of FADE_OUT toward mode 3 → all outputs at reset values.
  - After release, bgMode stays 0 with no further fade.
  - frameCount wraps 0xFFFF→0.
